tape_progress_writer: RTL and testbench
=======================================

// Module: tape_progress_writer
// PURPOSE
//  Parametrised successor to the cassette overlay's hard-wired progress logic. It watches
//  tape position against tape length. It computes a proportional fill count with a
//  sequential divider, then streams tile writes into port A of the overlay character-index
//  RAM: two spinning wheel tiles, then a BAR_LEN-tile progress bar. Runs in the pixel clock
//  domain; the overlay renderer reads the same RAM on port B.
// PARAMETERS
//  POS_W        24       width of i_pos / i_max
//  ADDR_W       11       char RAM address width
//  BAR_LEN      10       bar length in tiles, legal 1..31
//  BAR_ADDR     147      RAM address of leftmost bar tile
//  WHEEL_L_ADDR 339      RAM address of left wheel tile
//  WHEEL_R_ADDR 348      RAM address of right wheel tile
//  CH_EMPTY     8'hA6    unfilled bar tile code
//  CH_FULL      8'h7F    filled bar tile code
//  WHEEL_A      8'h2A    wheel frame A tile code
//  WHEEL_B      8'h96    wheel frame B tile code
// PORTS
//  i_pix      in   1       pixel clock, all logic on rising edge
//  reset_n    in   1       asynchronous active-low reset
//  i_max      in   POS_W   tape length; 0 = unknown
//  i_pos      in   POS_W   current tape position
//  i_force    in   1       1-cycle pulse: redraw bar without advancing wheels
//  o_wr_ena   out  1       char RAM write strobe
//  o_wr_addr  out  ADDR_W  char RAM write address
//  o_wr_data  out  8       char RAM write data (tile code)
//  o_busy     out  1       high from DIV through DONE
//  o_blocks   out  5       last computed fill count, 0..BAR_LEN
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; o_wr_ena=0, o_wr_addr=0, o_wr_data=0, o_busy=0,
//   o_blocks=0. Also clears pos_r=0, wheel=0, pending=0, adv=0.
//  pos_r<=i_pos every cycle. chg = (i_pos!=pos_r). trig = chg | i_force.
//  FSM: IDLE -> DIV -> WHL_L -> WHL_R -> BAR -> DONE -> IDLE.
//   IDLE: on trig, latch P=i_pos, M=i_max, adv=chg, and go to DIV. If neither, stay.
//   DIV: restoring division Q=(P*BAR_LEN)/M. Numerator width POS_W+5, one quotient bit per
//    cycle, exactly POS_W+5 cycles. After the last cycle: if M==0, blocks=0; otherwise
//    blocks=min(Q,BAR_LEN), i.e. pos>max saturates. o_blocks updates at DIV exit.
//   WHL_L: one write to WHEEL_L_ADDR, data WHEEL_A if wheel=1 else WHEEL_B.
//   WHL_R: one write to WHEEL_R_ADDR, data WHEEL_B if wheel=1 else WHEEL_A.
//    If adv=1, toggle wheel at the end of this state. Force-only runs never spin the wheels.
//    Both wheel writes occur in every run, force-only runs included.
//   BAR: BAR_LEN consecutive writes, i=0..BAR_LEN-1. Address BAR_ADDR+i, data CH_FULL if
//    i<blocks else CH_EMPTY. Leaves BAR after i=BAR_LEN-1.
//   DONE: o_wr_ena=0. If pending, clear it, latch the current i_pos/i_max/adv and go to
//    DIV; else go to IDLE.
//  o_wr_ena is high exactly in WHL_L, WHL_R and BAR cycles: BAR_LEN+2 writes per run,
//   with no gaps. Addr and data are registered together with the strobe.
//  Latency: trig sampled at edge k; first write visible after edge k+POS_W+6; last write
//   after edge k+POS_W+BAR_LEN+7.
//  trig while busy (DIV..DONE): set pending and OR chg into a pending-adv bit. Multiple
//   triggers collapse to one rerun. The rerun always uses the latest i_pos, never stale.
//  i_pos/i_max changes during DIV do not affect the quotient in flight.
//  BAR_LEN=1: the bar is a single write; blocks is 0 or 1.
//  reset_n asserted mid-run: the run is aborted, the strobe drops immediately, and no
//   partial write completes.
// TESTING
//  T1 reset: reset_n=0 mid-BAR -> o_wr_ena=0 same instant; all outputs 0; idle after release.
//  T2 i_max=1600, i_pos 0->800, BAR_LEN=10 -> o_blocks=5; 12 writes:
//   339=WHEEL_B, 348=WHEEL_A, 147..151=7F, 152..156=A6; first write at edge k+30.
//  T3 two pos changes 1600 then 1601, then i_force -> wheel frames alternate on the two
//   pos-change runs; forced run repeats the last frame; bar all 7F.
//  T4 boundaries: i_max=0 -> blocks=0 (all A6); i_pos=2000>i_max=1600 -> blocks=10;
//   i_pos=159, i_max=1600 -> blocks=0; i_pos=160 -> blocks=1.
//  T5 i_pos changes 3 times during one run -> exactly one rerun, using the final i_pos,
//   with wheel advancing once; no dropped or extra strobes.
//  T6 BAR_LEN=16, BAR_ADDR=0 -> writes at addresses 0..15; blocks never exceeds 16.

Source files
------------

// File: rtl/tape_progress_writer.sv
// Tape progress overlay writer.
// Watches the tape position against the tape length. It derives a proportional fill count
// with a bit-serial restoring divider. It then streams tile writes into port A of the
// overlay character RAM: the two wheel tiles first, then the progress bar.
module tape_progress_writer #(
    parameter int         POS_W        = 24,
    parameter int         ADDR_W       = 11,
    parameter int         BAR_LEN      = 10,
    parameter int         BAR_ADDR     = 147,
    parameter int         WHEEL_L_ADDR = 339,
    parameter int         WHEEL_R_ADDR = 348,
    parameter logic [7:0] CH_EMPTY     = 8'hA6,
    parameter logic [7:0] CH_FULL      = 8'h7F,
    parameter logic [7:0] WHEEL_A      = 8'h2A,
    parameter logic [7:0] WHEEL_B      = 8'h96
) (
    input  logic              i_pix,
    input  logic              reset_n,
    input  logic [POS_W-1:0]  i_max,
    input  logic [POS_W-1:0]  i_pos,
    input  logic              i_force,
    output logic              o_wr_ena,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy,
    output logic [4:0]        o_blocks
);

    // Numerator is pos*BAR_LEN; BAR_LEN <= 31 needs five extra bits.
    localparam int NUM_W = POS_W + 5;
    localparam int CNT_W = $clog2(NUM_W + 1);
    // The step counter runs 0..NUM_W-1 doing one quotient bit each; at NUM_W the result is taken.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_W);
    localparam logic [4:0]       LAST_IDX  = 5'(BAR_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_WHL_L,
        S_WHL_R,
        S_BAR,
        S_DONE
    } state_t;

    state_t state;

    logic [POS_W-1:0] pos_r;
    logic             chg;
    logic             trig;
    logic             pending;
    logic             pend_adv;
    logic             adv;
    logic             wheel;
    logic [CNT_W-1:0] step_cnt;
    logic [4:0]       idx;
    logic [4:0]       next_idx;

    logic [NUM_W-1:0] num_p0;
    logic [NUM_W-1:0] quot_p0;
    logic [POS_W-1:0] rem_p0;
    logic [POS_W-1:0] max_p0;
    logic [POS_W:0]   shifted;
    logic [POS_W-1:0] diff;
    logic             ge;
    logic             load;
    logic             step;

    // Fill count: an unknown length shows an empty bar, and a position past the end shows a full one.
    function automatic logic [4:0] sat_blocks(input logic [NUM_W-1:0] q,
                                              input logic [POS_W-1:0] m);
        logic [4:0] res;
        if (m == '0)
            res = 5'd0;
        else if (q > NUM_W'(BAR_LEN))
            res = 5'(BAR_LEN);
        else
            res = q[4:0];
        return res;
    endfunction

    // Tile code for bar position i given the fill count b.
    function automatic logic [7:0] bar_tile(input logic [4:0] i, input logic [4:0] b);
        return (i < b) ? CH_FULL : CH_EMPTY;
    endfunction

    assign chg      = (i_pos != pos_r);
    assign trig     = chg | i_force;
    assign next_idx = idx + 5'd1;

    // One restoring-division step: bring down the next numerator bit and subtract if it fits.
    // When it fits, the true difference is below max, so the narrow subtraction is exact.
    assign shifted = {rem_p0, num_p0[NUM_W-1]};
    assign ge      = (shifted >= {1'b0, max_p0});
    assign diff    = shifted[POS_W-1:0] - max_p0;

    // A new run snapshots the live inputs, either from idle or as the collapsed rerun in DONE.
    assign load = ((state == S_IDLE) && trig) || ((state == S_DONE) && (pending || trig));
    assign step = (state == S_DIV) && (step_cnt != LAST_STEP);

    // Divider datapath: snapshot the operands on load, then shift out one quotient bit per step.
    always_ff @(posedge i_pix) begin
        if (load) begin
            num_p0  <= NUM_W'(i_pos) * NUM_W'(BAR_LEN);
            max_p0  <= i_max;
            rem_p0  <= '0;
            quot_p0 <= '0;
        end else if (step) begin
            num_p0  <= {num_p0[NUM_W-2:0], 1'b0};
            rem_p0  <= ge ? diff : shifted[POS_W-1:0];
            quot_p0 <= {quot_p0[NUM_W-2:0], ge};
        end
    end

    // Control FSM: sequence the divide and the tile writes. Strobe, address and data are registered together.
    always_ff @(posedge i_pix or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pos_r     <= '0;
            wheel     <= 1'b0;
            pending   <= 1'b0;
            pend_adv  <= 1'b0;
            adv       <= 1'b0;
            step_cnt  <= '0;
            idx       <= '0;
            o_wr_ena  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_busy    <= 1'b0;
            o_blocks  <= '0;
        end else begin
            pos_r <= i_pos;

            // Triggers that arrive mid-run collapse into a single rerun.
            // The rerun spins the wheels if any of those triggers was a position change.
            if ((state == S_DIV || state == S_WHL_L || state == S_WHL_R || state == S_BAR) && trig) begin
                pending  <= 1'b1;
                pend_adv <= pend_adv | chg;
            end

            case (state)
                S_IDLE: begin
                    if (trig) begin
                        adv      <= chg;
                        step_cnt <= '0;
                        o_busy   <= 1'b1;
                        state    <= S_DIV;
                    end
                end

                S_DIV: begin
                    if (step_cnt == LAST_STEP) begin
                        o_blocks  <= sat_blocks(quot_p0, max_p0);
                        o_wr_ena  <= 1'b1;
                        o_wr_addr <= ADDR_W'(WHEEL_L_ADDR);
                        o_wr_data <= wheel ? WHEEL_A : WHEEL_B;
                        state     <= S_WHL_L;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end

                S_WHL_L: begin
                    o_wr_addr <= ADDR_W'(WHEEL_R_ADDR);
                    o_wr_data <= wheel ? WHEEL_B : WHEEL_A;
                    state     <= S_WHL_R;
                end

                S_WHL_R: begin
                    if (adv)
                        wheel <= ~wheel;
                    idx       <= '0;
                    o_wr_addr <= ADDR_W'(BAR_ADDR);
                    o_wr_data <= bar_tile(5'd0, o_blocks);
                    state     <= S_BAR;
                end

                S_BAR: begin
                    if (idx == LAST_IDX) begin
                        o_wr_ena <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        idx       <= next_idx;
                        o_wr_addr <= ADDR_W'(BAR_ADDR) + ADDR_W'(next_idx);
                        o_wr_data <= bar_tile(next_idx, o_blocks);
                    end
                end

                S_DONE: begin
                    if (pending || trig) begin
                        pending  <= 1'b0;
                        pend_adv <= 1'b0;
                        adv      <= pend_adv | chg;
                        step_cnt <= '0;
                        state    <= S_DIV;
                    end else begin
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                end

                default: begin
                    o_wr_ena <= 1'b0;
                    o_busy   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tape_progress_writer.sv
// Bench for tape_progress_writer: two instances (10-tile bar and 16-tile bar at address 0),
// with directed and random runs checked against a write-list model built from the fill rules.
`timescale 1ns/1ps
module tb_tape_progress_writer;

    localparam int LA     = 10;
    localparam int LB     = 16;
    localparam int BASE_A = 147;
    localparam int BASE_B = 0;
    localparam logic [10:0] WL_ADDR = 11'd339;
    localparam logic [10:0] WR_ADDR = 11'd348;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] max_a, pos_a, max_b, pos_b;
    logic        force_a, force_b;
    logic        wr_ena_a, wr_ena_b;
    logic [10:0] wr_addr_a, wr_addr_b;
    logic [7:0]  wr_data_a, wr_data_b;
    logic        busy_a, busy_b;
    logic [4:0]  blocks_a, blocks_b;

    tape_progress_writer dut_a (
        .i_pix(clk), .reset_n(reset_n), .i_max(max_a), .i_pos(pos_a), .i_force(force_a),
        .o_wr_ena(wr_ena_a), .o_wr_addr(wr_addr_a), .o_wr_data(wr_data_a),
        .o_busy(busy_a), .o_blocks(blocks_a)
    );

    tape_progress_writer #(.BAR_LEN(LB), .BAR_ADDR(BASE_B)) dut_b (
        .i_pix(clk), .reset_n(reset_n), .i_max(max_b), .i_pos(pos_b), .i_force(force_b),
        .o_wr_ena(wr_ena_b), .o_wr_addr(wr_addr_b), .o_wr_data(wr_data_b),
        .o_busy(busy_b), .o_blocks(blocks_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [18:0] obs_a[$];
    logic [18:0] obs_b[$];
    int          cyc_a[$];
    logic [18:0] exp_q[$];
    int          wheel_m[2];
    int          exp_blocks[2];
    int          errors = 0;
    int          checks = 0;

    always @(negedge clk) begin
        if (wr_ena_a) begin
            obs_a.push_back({wr_addr_a, wr_data_a});
            cyc_a.push_back(cyc);
        end
        if (wr_ena_b) obs_b.push_back({wr_addr_b, wr_data_b});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_blocks(input longint pos, input longint mx, input int len);
        longint q;
        if (mx == 0) return 0;
        q = (pos * len) / mx;
        return (q > len) ? len : int'(q);
    endfunction

    // Append the writes one run should produce and advance the modelled wheel.
    task automatic expect_run(input int which, input longint pos, input longint mx, input bit adv);
        int len, base, b;
        len  = (which != 0) ? LB : LA;
        base = (which != 0) ? BASE_B : BASE_A;
        b    = model_blocks(pos, mx, len);
        exp_q.push_back({WL_ADDR, (wheel_m[which] != 0) ? 8'h2A : 8'h96});
        exp_q.push_back({WR_ADDR, (wheel_m[which] != 0) ? 8'h96 : 8'h2A});
        for (int i = 0; i < len; i++)
            exp_q.push_back({11'(base + i), (i < b) ? 8'h7F : 8'hA6});
        if (adv) wheel_m[which] = 1 - wheel_m[which];
        exp_blocks[which] = b;
    endtask

    task automatic clear_all();
        obs_a.delete();
        obs_b.delete();
        cyc_a.delete();
        exp_q.delete();
    endtask

    task automatic compare_writes(input string tag, input int which);
        int n;
        logic [18:0] o;
        n = (which != 0) ? obs_b.size() : obs_a.size();
        check({tag, ".count"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            o = 'x;
            if (i < n) o = (which != 0) ? obs_b[i] : obs_a[i];
            check($sformatf("%s.w%0d", tag, i), 64'(o), 64'(exp_q[i]));
        end
        check({tag, ".blocks"}, (which != 0) ? 64'(blocks_b) : 64'(blocks_a), 64'(exp_blocks[which]));
        check({tag, ".busy"}, (which != 0) ? 64'(busy_b) : 64'(busy_a), 64'd0);
    endtask

    // Change position (and length) at a negedge; k is the edge that samples the trigger.
    task automatic run_pos(input int which, input logic [23:0] p, input logic [23:0] m, output int k);
        logic [23:0] old;
        clear_all();
        old = (which != 0) ? pos_b : pos_a;
        k = cyc + 1;
        if (which != 0) begin pos_b = p; max_b = m; end
        else begin pos_a = p; max_a = m; end
        expect_run(which, p, m, p != old);
        repeat (60) @(negedge clk);
    endtask

    task automatic force_run(input int which);
        clear_all();
        if (which != 0) force_b = 1'b1; else force_a = 1'b1;
        expect_run(which, (which != 0) ? pos_b : pos_a, (which != 0) ? max_b : max_a, 1'b0);
        @(negedge clk);
        force_a = 1'b0;
        force_b = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic random_run(input int which, input string tag);
        logic [23:0] m, p, old;
        int lim, k;
        m = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom_range(1, 32'hFFFFFF));
        lim = (m == 0) ? 5000 : int'(m) + int'(m) / 4;
        if (lim > 32'hFFFFFF) lim = 32'hFFFFFF;
        p = 24'($urandom_range(0, lim));
        old = (which != 0) ? pos_b : pos_a;
        if (p == old) p = p ^ 24'd1;
        run_pos(which, p, m, k);
        compare_writes(tag, which);
        if ($urandom_range(0, 3) == 0) begin
            force_run(which);
            compare_writes({tag, ".force"}, which);
        end
    endtask

    initial begin
        int k;
        max_a = 0; pos_a = 0; force_a = 0;
        max_b = 0; pos_b = 0; force_b = 0;
        wheel_m[0] = 0; wheel_m[1] = 0;
        exp_blocks[0] = 0; exp_blocks[1] = 0;

        repeat (3) @(negedge clk);
        check("rst.wr_ena", 64'(wr_ena_a), 64'd0);
        check("rst.addr", 64'(wr_addr_a), 64'd0);
        check("rst.data", 64'(wr_data_a), 64'd0);
        check("rst.busy", 64'(busy_a), 64'd0);
        check("rst.blocks", 64'(blocks_a), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // T1: reset in the middle of the bar.
        max_a = 24'd1600;
        pos_a = 24'd800;
        k = cyc + 1;
        repeat (36) @(negedge clk);
        check("t1.midbar_wr_ena", 64'(wr_ena_a), 64'd1);
        check("t1.midbar_busy", 64'(busy_a), 64'd1);
        #2 reset_n = 1'b0;
        pos_a = 0;
        max_a = 0;
        #1;
        check("t1.wr_ena", 64'(wr_ena_a), 64'd0);
        check("t1.addr", 64'(wr_addr_a), 64'd0);
        check("t1.data", 64'(wr_data_a), 64'd0);
        check("t1.busy", 64'(busy_a), 64'd0);
        check("t1.blocks", 64'(blocks_a), 64'd0);
        @(negedge clk);
        clear_all();
        wheel_m[0] = 0; wheel_m[1] = 0;
        exp_blocks[0] = 0; exp_blocks[1] = 0;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t1.idle_busy", 64'(busy_a), 64'd0);
        check("t1.idle_writes", 64'(obs_a.size()), 64'd0);

        // T2: half-way position, plus first/last write latency.
        run_pos(0, 24'd800, 24'd1600, k);
        compare_writes("t2", 0);
        check("t2.first_edge", 64'((cyc_a.size() > 0) ? cyc_a[0] : -1), 64'(k + 30));
        check("t2.last_edge", 64'((cyc_a.size() > 0) ? cyc_a[cyc_a.size() - 1] : -1), 64'(k + 41));

        // T3: two position changes then a force.
        run_pos(0, 24'd1600, 24'd1600, k);
        compare_writes("t3.a", 0);
        run_pos(0, 24'd1601, 24'd1600, k);
        compare_writes("t3.b", 0);
        force_run(0);
        compare_writes("t3.force", 0);

        // T4: boundaries.
        run_pos(0, 24'd500, 24'd0, k);
        compare_writes("t4.max0", 0);
        run_pos(0, 24'd2000, 24'd1600, k);
        compare_writes("t4.over", 0);
        run_pos(0, 24'd159, 24'd1600, k);
        compare_writes("t4.p159", 0);
        run_pos(0, 24'd160, 24'd1600, k);
        compare_writes("t4.p160", 0);

        // T5: three position changes during one run collapse to one rerun using the last value.
        clear_all();
        pos_a = 24'd3000;
        max_a = 24'd1600;
        expect_run(0, 3000, 1600, 1'b1);
        repeat (5) @(negedge clk);
        pos_a = 24'd100;
        repeat (7) @(negedge clk);
        pos_a = 24'd200;
        repeat (8) @(negedge clk);
        pos_a = 24'd400;
        expect_run(0, 400, 1600, 1'b1);
        repeat (120) @(negedge clk);
        compare_writes("t5", 0);

        // Length change during the divide affects neither the quotient nor triggers a rerun.
        clear_all();
        pos_a = 24'd900;
        expect_run(0, 900, 1600, 1'b1);
        repeat (10) @(negedge clk);
        max_a = 24'd800;
        repeat (60) @(negedge clk);
        compare_writes("t5.maxmid", 0);

        // Random runs on the 10-tile instance.
        for (int r = 0; r < 8; r++) random_run(0, $sformatf("rnd_a%0d", r));

        // T6: 16-tile bar at address 0.
        run_pos(1, 24'd800, 24'd1600, k);
        compare_writes("t6.half", 1);
        run_pos(1, 24'd5000, 24'd1600, k);
        compare_writes("t6.over", 1);
        check("t6.blocks_max", 64'(blocks_b <= 5'd16), 64'd1);
        run_pos(1, 24'd1599, 24'd1600, k);
        compare_writes("t6.p1599", 1);
        force_run(1);
        compare_writes("t6.force", 1);
        for (int r = 0; r < 4; r++) random_run(1, $sformatf("rnd_b%0d", r));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
